bilinear_interp: RTL
====================

Name: bilinear_interp

Overview:
- Downstream consumer of the four-bank image buffer: issues integer read coordinates to it, absorbs its 2-cycle read latency, and blends the returned lu/ru/ld/rd quad with fractional weights into one output pixel.
- Upstream sits the rectification coordinate generator, which supplies one source coordinate per output pixel as integer and fraction parts.
- Emits a raster-ordered output pixel stream with position and frame markers.

Parameters:
IMG_W, 8, source image width in pixels; must equal the buffer's img_width.
IMG_H, 8, source image height in pixels; must equal the buffer's img_height.
OUT_W, 8, output frame width, in pixels per line.
OUT_H, 8, output frame height, in lines.
FRAC_W, 6, fraction bits per axis.
FILL, 0, 8-bit pixel emitted for out-of-bounds requests.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, synchronous, active-low.
in_valid  in  1  request strobe, one per output pixel.
in_x, in_y  in  10 each  integer source coordinate.
in_fx, in_fy  in  FRAC_W each  fractional source coordinate.
in_oob  in  1  coordinate falls outside the source image.
rx, ry  out  10 each  read coordinate to the image buffer.
lu, ru, ld, rd  in  8 each  neighbour pixels returned by the image buffer.
out_valid  out  1  output pixel strobe.
out_pix  out  8  interpolated pixel.
out_x, out_y  out  10 each  output raster position of out_pix.
out_sof, out_eol, out_eof  out  1 each  first pixel of frame, last pixel of line, last pixel of frame; qualified by out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. No backpressure; the block accepts one request per cycle.
- Reset state, held while rst_n=0: rx=ry=0, out_valid=0, out_pix=0, out_x=out_y=0, all flags 0, every pipeline valid bit 0.
- Reset mid-operation: in-flight requests are discarded (no output for them) and the raster counters restart at (0,0).
- Cycle t, request capture: registers in_x/in_y onto rx/ry; valid, fx, fy and oob enter a delay line.
- Edge clamp at capture:
  - if in_x==IMG_W-1, fx is forced to 0;
  - if in_y==IMG_H-1, fy is forced to 0;
  - this prevents weighting the wrapped or duplicated neighbour the buffer returns at the edge.
- Bound check at capture: if in_x>=IMG_W or in_y>=IMG_H, oob is forced to 1 and rx/ry are held at their previous value.
- t+3: lu/ru/ld/rd for the request are valid (buffer latency 2 after rx/ry). Delayed fx/fy/oob are aligned to this cycle.
- t+4: horizontal blend, registered:
  - top = lu*(2^FRAC_W-fx) + ru*fx;
  - bot = ld*(2^FRAC_W-fx) + rd*fx;
  - each is 8+FRAC_W bits, unsigned.
- t+5: vertical blend, registered: acc = top*(2^FRAC_W-fy) + bot*fy, 8+2*FRAC_W bits.
- t+6: output register:
  - out_pix = (acc + 2^(2*FRAC_W-1)) >> (2*FRAC_W), saturated to 255 (saturation is defensive only);
  - if oob, out_pix = FILL;
  - out_valid=1.
- Fixed request-to-output latency: 6 cycles. Back-to-back requests produce back-to-back outputs; gaps are preserved.
- Raster counters: advance only on out_valid.
  - out_x increments; at OUT_W-1 it wraps to 0 and out_y increments.
  - at (OUT_W-1, OUT_H-1) both wrap to 0.
- Flags:
  - out_sof=1 at (0,0);
  - out_eol=1 when out_x==OUT_W-1;
  - out_eof=1 when at (OUT_W-1, OUT_H-1); out_eof implies out_eol.
- Width rule: all products are unsigned with no truncation before the final shift.
- fx=0 and fy=0 reproduces lu exactly.

Decomposition:
- Shared package rect_pkg: PIX_W=8, COORD_W=10, FRAC_W, ONE=2^FRAC_W, the rounding constant, and the pipeline-latency constant BUF_LAT=2 used by both this block and its testbench.
- Sub-module lerp_1d: registered single-axis blend, a*(ONE-f)+b*f with parameterised operand width.
  - instantiated twice at t+4 (top, bot) and once at t+5.

Test Plan:
- Constant image 100, random fx/fy, continuous requests -> every out_pix=100, out_valid exactly 6 cycles after each in_valid.
- lu=0, ru=255, ld=0, rd=255, fx=32, fy=0 (FRAC_W=6) -> out_pix=128 (127.5 rounds up).
- Quad lu=10, ru=20, ld=30, rd=40, fx=fy=32 -> top=15, bot=35, out_pix=25.
- in_x=IMG_W-1, fx=63 -> fx treated as 0, out_pix=lu. in_x=IMG_W (out of range) -> out_pix=FILL, rx/ry unchanged.
- Full 8x8 output frame with a 1-cycle gap every 3 requests -> 64 outputs, sof on the first, eol on every 8th, eof on the 64th, then counters back to (0,0).
- Deassert rst_n for 1 cycle while 4 requests are in flight -> zero outputs for them; the next request yields out_x=out_y=0 with sof=1.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared constants for the rectification datapath: pixel/coordinate widths,
// fixed-point fraction format and the image-buffer read latency.
package rect_pkg;
    localparam int PIX_W   = 8;
    localparam int COORD_W = 10;
    localparam int FRAC_W  = 6;
    localparam int ONE     = 1 << FRAC_W;
    localparam int ROUND   = 1 << (2 * FRAC_W - 1);
    localparam int BUF_LAT = 2;

    typedef logic [PIX_W-1:0]   pix_t;
    typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/bilinear_interp_lerp_1d.sv
// Registered single-axis linear blend y = a*(ONE-f) + b*f, unsigned.
module lerp_1d import rect_pkg::*; #(
    parameter int A_W = PIX_W,
    parameter int F_W = FRAC_W
) (
    input  logic             clk,
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    input  logic [F_W-1:0]   f,
    output logic [A_W+F_W-1:0] y
);
    localparam int Y_W = A_W + F_W;
    localparam logic [F_W:0] ONE_F = {1'b1, {F_W{1'b0}}};

    logic [F_W:0]   wa;
    logic [Y_W-1:0] sum;

    // The full blend never exceeds max(a,b)*ONE, so Y_W bits hold it exactly.
    assign wa  = ONE_F - {1'b0, f};
    assign sum = Y_W'(a) * Y_W'(wa) + Y_W'(b) * Y_W'(f);

    always_ff @(posedge clk) begin
        y <= sum;
    end
endmodule

// File: rtl/bilinear_interp.sv
// Bilinear interpolator: issues read coordinates to the four-bank image buffer,
// absorbs its read latency and blends the returned quad into a raster pixel stream.
module bilinear_interp import rect_pkg::*; #(
    parameter int         IMG_W  = 8,
    parameter int         IMG_H  = 8,
    parameter int         OUT_W  = 8,
    parameter int         OUT_H  = 8,
    parameter int         FRAC_W = rect_pkg::FRAC_W,
    parameter logic [7:0] FILL   = 8'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [FRAC_W-1:0]  in_fx,
    input  logic [FRAC_W-1:0]  in_fy,
    input  logic               in_oob,
    output logic [COORD_W-1:0] rx,
    output logic [COORD_W-1:0] ry,
    input  logic [PIX_W-1:0]   lu,
    input  logic [PIX_W-1:0]   ru,
    input  logic [PIX_W-1:0]   ld,
    input  logic [PIX_W-1:0]   rd,
    output logic               out_valid,
    output logic [PIX_W-1:0]   out_pix,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_eof
);
    localparam int H_W    = PIX_W + FRAC_W;
    localparam int ACC_W  = PIX_W + 2 * FRAC_W;
    localparam int STAGES = BUF_LAT + 3;

    logic                bound_oob, last_col, last_row;
    logic [STAGES:1]     v_q, oob_q;
    logic [FRAC_W-1:0]   fx_q [1:BUF_LAT+1];
    logic [FRAC_W-1:0]   fy_q [1:BUF_LAT+2];
    logic [H_W-1:0]      top, bot;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W:0]      acc_rnd;
    logic [PIX_W:0]      pix_w;
    logic [PIX_W-1:0]    pix_sat;
    logic [COORD_W-1:0]  cnt_x, cnt_y;
    logic                at_sof, at_eol, at_eof;

    assign bound_oob = (in_x >= COORD_W'(IMG_W)) || (in_y >= COORD_W'(IMG_H));
    assign last_col  = in_x == COORD_W'(IMG_W - 1);
    assign last_row  = in_y == COORD_W'(IMG_H - 1);

    // Out-of-range requests keep the last good read address on the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx    <= '0;
            ry    <= '0;
            v_q   <= '0;
            oob_q <= '0;
        end else begin
            v_q   <= {v_q[STAGES-1:1], in_valid};
            oob_q <= {oob_q[STAGES-1:1], in_oob | bound_oob};
            if (in_valid && !bound_oob) begin
                rx <= in_x;
                ry <= in_y;
            end
        end
    end

    // At the last column/row the buffer returns a duplicated neighbour; zero its weight.
    always_ff @(posedge clk) begin
        fx_q[1] <= last_col ? '0 : in_fx;
        fy_q[1] <= last_row ? '0 : in_fy;
        for (int i = 2; i <= BUF_LAT + 1; i++) fx_q[i] <= fx_q[i-1];
        for (int i = 2; i <= BUF_LAT + 2; i++) fy_q[i] <= fy_q[i-1];
    end

    lerp_1d #(.A_W(PIX_W), .F_W(FRAC_W)) u_top (
        .clk(clk), .a(lu), .b(ru), .f(fx_q[BUF_LAT+1]), .y(top)
    );
    lerp_1d #(.A_W(PIX_W), .F_W(FRAC_W)) u_bot (
        .clk(clk), .a(ld), .b(rd), .f(fx_q[BUF_LAT+1]), .y(bot)
    );
    lerp_1d #(.A_W(H_W), .F_W(FRAC_W)) u_vert (
        .clk(clk), .a(top), .b(bot), .f(fy_q[BUF_LAT+2]), .y(acc)
    );

    assign acc_rnd = {1'b0, acc} + (ACC_W+1)'(1 << (2 * FRAC_W - 1));
    assign pix_w   = (PIX_W+1)'(acc_rnd >> (2 * FRAC_W));
    assign pix_sat = pix_w[PIX_W] ? {PIX_W{1'b1}} : pix_w[PIX_W-1:0];

    assign at_sof = (cnt_x == '0) && (cnt_y == '0);
    assign at_eol = cnt_x == COORD_W'(OUT_W - 1);
    assign at_eof = at_eol && (cnt_y == COORD_W'(OUT_H - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            cnt_x     <= '0;
            cnt_y     <= '0;
        end else begin
            out_valid <= v_q[STAGES];
            out_sof   <= v_q[STAGES] && at_sof;
            out_eol   <= v_q[STAGES] && at_eol;
            out_eof   <= v_q[STAGES] && at_eof;
            if (v_q[STAGES]) begin
                out_pix <= oob_q[STAGES] ? FILL : pix_sat;
                out_x   <= cnt_x;
                out_y   <= cnt_y;
                cnt_x   <= at_eol ? '0 : cnt_x + COORD_W'(1);
                if (at_eof)      cnt_y <= '0;
                else if (at_eol) cnt_y <= cnt_y + COORD_W'(1);
            end
        end
    end
endmodule
